// File: rtl/pagerank_tile_if.sv
// NoC-side channels of a pagerank_tile: contribution request/response and
// the independent query/reply path. The master modport is the tile side.
interface pagerank_tile_if #(
  parameter int PW    = 6,
  parameter int WIDTH = 16
);
  // Handshake rules:
  // - A request transfers on a cycle where req_valid and req_ready are both 1.
  // - Once req_valid is raised, req_valid and req_page stay stable until that
  //   transfer happens.
  // - Responses (rsp_*) and queries (qry_*) are valid-only and have no
  //   backpressure.
  // - A reply (rpl_*) follows each query exactly one cycle later.
  logic             req_valid;
  logic [PW-1:0]    req_page;
  logic             req_ready;
  logic             rsp_valid;
  logic [PW-1:0]    rsp_page;
  logic [WIDTH-1:0] rsp_data;
  logic             qry_valid;
  logic [PW-1:0]    qry_page;
  logic             rpl_valid;
  logic [WIDTH-1:0] rpl_data;

  modport master (
    output req_valid, req_page, rpl_valid, rpl_data,
    input  req_ready, rsp_valid, rsp_page, rsp_data, qry_valid, qry_page
  );

  modport slave (
    input  req_valid, req_page, rpl_valid, rpl_data,
    output req_ready, rsp_valid, rsp_page, rsp_data, qry_valid, qry_page
  );
endinterface

// File: rtl/pagerank_tile.sv
// Jacobi PageRank tile owning N of M pages, with double-buffered values.
// Optional WAIT watchdog: define PAGERANK_TIMEOUT_EN.
module pagerank_tile #(
  parameter int               N     = 16,
  parameter int               M     = 64,
  parameter int               WIDTH = 16,
  parameter int               PW    = 6,
  parameter int               TW    = 2,
  parameter logic [WIDTH-1:0] D     = 16'h2666,
  parameter int               ITERS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [TW-1:0]        tile_id,
  input  logic [N*M-1:0]       adjacency,
  input  logic [N*WIDTH-1:0]   weights,
  pagerank_tile_if.master      noc,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           iter,
  output logic [N*WIDTH-1:0]   vals,
  output logic [2:0]           state_dbg
);
  localparam int NW = $clog2(N);
  localparam int AW = WIDTH + PW;
  localparam logic [WIDTH:0]   DB   = (WIDTH+1)'(1 << WIDTH) - (WIDTH+1)'(D);
  localparam logic [WIDTH-1:0] DN   = WIDTH'(D / M);
  localparam logic [WIDTH-1:0] INIT = WIDTH'((1 << WIDTH) / M);

  typedef enum logic [2:0] {
    IDLE = 3'd0, SCAN = 3'd1, REQ = 3'd2, WAIT = 3'd3,
    COMMIT = 3'd4, SWAP = 3'd5, DONE = 3'd6
  } state_t;

  state_t           state;
  logic [NW-1:0]    p;
  logic [PW-1:0]    k;
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] cur [N];
  logic [WIDTH-1:0] nxt [N];
  logic [WIDTH-1:0] w_arr [N];

  // Truncated (db * w * v) >> 2*WIDTH; db <= 2^WIDTH keeps the result in range.
  function automatic logic [WIDTH-1:0] contrib(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] w);
    logic [3*WIDTH:0] prod;
    prod = (3*WIDTH+1)'(DB) * (3*WIDTH+1)'(w) * (3*WIDTH+1)'(v);
    return WIDTH'(prod >> (2*WIDTH));
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign w_arr[i]                  = weights[i*WIDTH +: WIDTH];
    assign vals[i*WIDTH +: WIDTH]    = cur[i];
  end

  assign state_dbg = state;

  logic             adj_bit, k_local, k_last, p_last;
  logic [NW-1:0]    k_idx;
  logic [AW:0]      sum;
  logic [WIDTH-1:0] sat_val;

  // M is a power of two, so {p,k} is exactly the bit index p*M+k.
  assign adj_bit = adjacency[{p, k}];
  assign k_idx   = k[NW-1:0];
  assign k_local = (k[PW-1:NW] == tile_id);
  assign k_last  = (k == PW'(M-1));
  assign p_last  = (p == NW'(N-1));
  assign sum     = (AW+1)'(DN) + (AW+1)'(acc);
  assign sat_val = (|sum[AW:WIDTH]) ? '1 : sum[WIDTH-1:0];

`ifdef PAGERANK_TIMEOUT_EN
  logic [7:0] wd_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      p             <= '0;
      k             <= '0;
      acc           <= '0;
      iter          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      noc.req_valid <= 1'b0;
      noc.req_page  <= '0;
      for (int i = 0; i < N; i++) begin
        cur[i] <= INIT;
        nxt[i] <= INIT;
      end
`ifdef PAGERANK_TIMEOUT_EN
      wd_cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= SCAN;
            iter  <= '0;
            p     <= '0;
            k     <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        SCAN: begin
          if (adj_bit && !k_local) begin
            state         <= REQ;
            noc.req_valid <= 1'b1;
            noc.req_page  <= k;
          end else begin
            if (adj_bit) acc <= acc + AW'(contrib(cur[k_idx], w_arr[k_idx]));
            if (k_last) state <= COMMIT;
            else        k     <= k + 1'b1;
          end
        end
        REQ: begin
          if (noc.req_ready) begin
            state         <= WAIT;
            noc.req_valid <= 1'b0;
`ifdef PAGERANK_TIMEOUT_EN
            wd_cnt        <= '0;
`endif
          end
        end
        WAIT: begin
          if (noc.rsp_valid && noc.rsp_page == k) begin
            acc <= acc + AW'(noc.rsp_data);
            if (k_last) state <= COMMIT;
            else begin
              state <= SCAN;
              k     <= k + 1'b1;
            end
          end
`ifdef PAGERANK_TIMEOUT_EN
          else if (wd_cnt == 8'd255) begin
            state         <= REQ;
            noc.req_valid <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        COMMIT: begin
          nxt[p] <= sat_val;
          acc    <= '0;
          k      <= '0;
          if (p_last) state <= SWAP;
          else begin
            state <= SCAN;
            p     <= p + 1'b1;
          end
        end
        SWAP: begin
          for (int i = 0; i < N; i++) cur[i] <= nxt[i];
          iter <= iter + 1'b1;
          p    <= '0;
          if (iter + 8'd1 == 8'(ITERS)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= SCAN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Query path never looks at the FSM, so neighbouring tiles always get answers.
  logic [NW-1:0] q_idx;
  logic          q_local;
  assign q_idx   = noc.qry_page[NW-1:0];
  assign q_local = (noc.qry_page[PW-1:NW] == tile_id);

  always_ff @(posedge clk) begin
    if (reset) begin
      noc.rpl_valid <= 1'b0;
      noc.rpl_data  <= '0;
    end else begin
      noc.rpl_valid <= noc.qry_valid;
      noc.rpl_data  <= (noc.qry_valid && q_local) ? contrib(cur[q_idx], w_arr[q_idx]) : '0;
    end
  end
endmodule

// File: tb/tb_pagerank_tile.sv
// Directed bench for pagerank_tile (ITERS=1): reset state, local/remote
// contributions, request handshake, query path and mid-run reset.
module tb_pagerank_tile;
  localparam int N = 16, M = 64, WIDTH = 16, PW = 6, TW = 2;

  logic                 clk = 1'b0;
  logic                 reset, start;
  logic [TW-1:0]        tile_id;
  logic [N*M-1:0]       adjacency;
  logic [N*WIDTH-1:0]   weights;
  logic                 busy, done;
  logic [7:0]           iter;
  logic [N*WIDTH-1:0]   vals;
  logic [2:0]           state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_q[$];

  pagerank_tile_if #(.PW(PW), .WIDTH(WIDTH)) noc ();

  pagerank_tile #(.N(N), .M(M), .WIDTH(WIDTH), .PW(PW), .TW(TW),
                  .D(16'h2666), .ITERS(1)) dut (
    .clk(clk), .reset(reset), .start(start), .tile_id(tile_id),
    .adjacency(adjacency), .weights(weights), .noc(noc.master),
    .busy(busy), .done(done), .iter(iter), .vals(vals), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic apply_reset();
    reset = 1'b1; start = 1'b0; tile_id = '0; adjacency = '0; weights = '0;
    noc.req_ready = 1'b0; noc.rsp_valid = 1'b0; noc.rsp_page = '0; noc.rsp_data = '0;
    noc.qry_valid = 1'b0; noc.qry_page = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cnt = 0;
    while (!done && cnt < 5000) begin tick(); cnt++; end
    check(tag, done, 1);
  endtask

  task automatic wait_req(input string tag);
    int cnt = 0;
    while (!noc.req_valid && cnt < 2000) begin tick(); cnt++; end
    check(tag, noc.req_valid, 1);
  endtask

  // scoreboard: expected page values, page 0 distinct from the rest
  task automatic check_vals(input string tag, input logic [WIDTH-1:0] v0,
                            input logic [WIDTH-1:0] vrest);
    exp_q.push_back(v0);
    for (int i = 1; i < N; i++) exp_q.push_back(vrest);
    for (int i = 0; i < N; i++) begin
      logic [WIDTH-1:0] e;
      e = exp_q.pop_front();
      check($sformatf("%s_val%0d", tag, i), vals[i*WIDTH +: WIDTH], e);
    end
  endtask

  initial begin
    int cnt;
    // Reset and idle
    apply_reset();
    repeat (10) tick();
    check_vals("rst", 16'h0400, 16'h0400);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req_valid", noc.req_valid, 0);
    check("rst_rpl_valid", noc.rpl_valid, 0);
    check("rst_iter", iter, 0);
    check("rst_state", state_dbg, 0);

    // No links: every value becomes dn = 153
    pulse_start();
    check("run0_busy", busy, 1);
    cnt = 1;
    while (!done && cnt < 3000) begin tick(); cnt++; end
    check("run0_latency", cnt, 1042);
    check_vals("run0", 16'h0099, 16'h0099);
    check("run0_iter", iter, 1);
    check("run0_busy_end", busy, 0);
    repeat (3) tick();
    check("run0_done_held", done, 1);

    // One local link: 153 + contrib(0x400, 0x8000) = 153 + 435
    apply_reset();
    adjacency[0*M + 1] = 1'b1;
    weights[1*WIDTH +: WIDTH] = 16'h8000;
    pulse_start();
    wait_done("local_done");
    check_vals("local", 16'h024C, 16'h0099);

    // One remote link with ready stall, wrong-page response, then right one
    apply_reset();
    adjacency[0*M + 40] = 1'b1;
    pulse_start();
    wait_req("remote_req");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall%0d_valid", i), noc.req_valid, 1);
      check($sformatf("stall%0d_page", i), noc.req_page, 40);
      tick();
    end
    check("stall_state", state_dbg, 2);
    noc.req_ready = 1'b1;
    tick();
    noc.req_ready = 1'b0;
    check("hs_req_dropped", noc.req_valid, 0);
    check("hs_state_wait", state_dbg, 3);
    noc.rsp_valid = 1'b1; noc.rsp_page = 6'd41; noc.rsp_data = 16'hFFFF;
    tick();
    check("wrong_rsp_state", state_dbg, 3);
    noc.rsp_page = 6'd40; noc.rsp_data = 16'h0100;
    tick();
    noc.rsp_valid = 1'b0;
    check("rsp_back_to_scan", state_dbg, 1);
    wait_done("remote_done");
    check_vals("remote", 16'h0199, 16'h0099);

    // Queries while stalled in WAIT on tile 1
    apply_reset();
    tile_id = 2'd1;
    adjacency[0*M + 0] = 1'b1;
    weights[1*WIDTH +: WIDTH] = 16'h8000;
    pulse_start();
    wait_req("q_req");
    noc.req_ready = 1'b1;
    tick();
    noc.req_ready = 1'b0;
    check("q_state_wait", state_dbg, 3);
    noc.qry_valid = 1'b1; noc.qry_page = 6'd17;
    tick();
    check("q17_valid", noc.rpl_valid, 1);
    check("q17_data", noc.rpl_data, 435);
    noc.qry_page = 6'd3;
    tick();
    check("q3_valid", noc.rpl_valid, 1);
    check("q3_data", noc.rpl_data, 0);
    noc.qry_page = 6'd16;
    tick();
    check("q16_data", noc.rpl_data, 0);
    noc.qry_valid = 1'b0;
    tick();
    check("q_idle_valid", noc.rpl_valid, 0);

    // Mid-run reset while waiting for a response
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_state", state_dbg, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req", noc.req_valid, 0);
    check("mid_rst_iter", iter, 0);
    check_vals("mid_rst", 16'h0400, 16'h0400);

`ifdef PAGERANK_TIMEOUT_EN
    // Withheld response: request reissued 256 cycles after entering WAIT
    apply_reset();
    adjacency[0*M + 40] = 1'b1;
    pulse_start();
    wait_req("wd_req");
    noc.req_ready = 1'b1;
    tick();
    noc.req_ready = 1'b0;
    cnt = 0;
    while (!noc.req_valid && cnt < 400) begin tick(); cnt++; end
    check("wd_latency", cnt, 256);
    check("wd_page", noc.req_page, 40);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pagerank_tile.md
# pagerank_tile

Parametrised PageRank compute tile, successor to the single-iteration page node. Owns N local pages of an M-page graph and runs a configurable number of synchronous (Jacobi) PageRank iterations with double-buffered values. Fetches remote contributions through a valid/ready request channel to the NoC. Answers NoC queries for its own pages at any time, so tiles cannot deadlock on each other.

## Interface
- N, 16, local pages per tile
- M, 64, total pages in graph; M is a multiple of N
- WIDTH, 16, unsigned fixed-point width; value = raw / 2^WIDTH
- PW, 6, page index width, equal to log2(M)
- TW, 2, tile id width, equal to log2(M/N)
- D, 16'h2666, damping teleport term d (0.15 at WIDTH=16)
- ITERS, 8, iterations per run; range 1..255
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a run
- tile_id  in  TW  this tile's id; local pages are tile_id*N .. tile_id*N+N-1
- adjacency  in  N*M  row p, bit k = local page p receives a link from global page k; bit index p*M+k
- weights  in  N*WIDTH  out-weight (1/outdegree) of each local page
- req_valid  out  1  remote contribution request
- req_page  out  PW  global page requested
- req_ready  in  1  NoC accepts request
- rsp_valid  in  1  response valid
- rsp_page  in  PW  page of response
- rsp_data  in  WIDTH  contribution value
- qry_valid  in  1  NoC query valid
- qry_page  in  PW  global page queried
- rpl_valid  out  1  reply valid
- rpl_data  out  WIDTH  reply value
- busy  out  1  run in progress
- done  out  1  run finished; held until next start or reset
- iter  out  8  completed iterations
- vals  out  N*WIDTH  current values; local page p at [p*WIDTH +: WIDTH]

## Operation
- Definitions:
  - db = 2^WIDTH - D.
  - dn = D / M, truncated.
  - contrib(v,w) = (db*w*v) >> (2*WIDTH), truncated.
- Reset: every cur value = 2^WIDTH / M (0x0400 at defaults). State IDLE. All outputs 0 except vals.
- FSM:
  - IDLE: on start, iter=0 and go to SCAN with p=0, k=0, acc=0.
  - SCAN: handles one column k per cycle.
    - If adj[p][k]=0, skip.
    - If adj[p][k]=1 and k is local, acc += contrib(cur[k-local_base], weight[k-local_base]).
    - If adj[p][k]=1 and k is remote, raise req_valid with req_page=k and go to REQ.
    - After k=M-1, go to COMMIT.
  - REQ: hold req_valid and req_page stable until req_ready. On handshake go to WAIT.
  - WAIT: on rsp_valid with rsp_page==k, acc += rsp_data, then return to SCAN at k+1, or COMMIT if k=M-1. Responses with any other page are dropped.
  - COMMIT: nxt[p] = min(dn + acc, 2^WIDTH-1). Clear acc, then:
    - p<N-1: p++, SCAN.
    - p=N-1: SWAP.
  - SWAP: cur = nxt, iter++.
    - iter==ITERS: go to DONE.
    - Otherwise: SCAN with p=0.
  - DONE: done=1. On start, behave as in IDLE.
- acc is WIDTH+PW bits wide; saturation is applied only at COMMIT.
- All contributions use cur values only. nxt is invisible until SWAP.
- Query path runs independently of the FSM state.
  - qry_valid at cycle t gives rpl_valid=1 at t+1.
  - rpl_data = contrib(cur, weight) of the queried page if it is local, else 0.
  - Back-to-back queries are answered one per cycle.
- busy=1 in every state except IDLE and DONE.
- start while busy is ignored.
- Synchronous reset mid-run aborts immediately: return to IDLE, restore reset values, drop any pending request.

## Timing
- SCAN spends one cycle per column. COMMIT and SWAP take one cycle each.
- With no remote links, one iteration takes N*(M+1)+1 cycles: 1041 at defaults.
- Each remote link adds 1 REQ cycle plus any req_ready stall, plus the wait for the response.
- Responses are accepted only in WAIT. A response in the same cycle as the req_ready handshake is dropped; the NoC guarantees at least 1 cycle of response latency.
- vals updates only on the SWAP cycle.
- done rises the cycle after the final SWAP.

## Configuration
- PAGERANK_TIMEOUT_EN defined: an 8-bit watchdog counts cycles spent in WAIT. At 255 it returns the FSM to REQ and reissues the same req_page. The counter clears on entering WAIT.
- Not defined: WAIT holds indefinitely and there is no watchdog logic.

## Test plan
- Reset, then idle 10 cycles -> all vals 0x0400; busy, done, req_valid, rpl_valid and iter all 0.
- Adjacency all 0, ITERS=1, start -> done at cycle 1042; every val = 0x0099 (dn=153).
- tile_id=0, adj[0][1]=1, weight[1]=0x8000, ITERS=1 -> val0 = 153+435 = 0x024C; other vals 0x0099.
- adj[0][40]=1 with tile_id=0:
  - req_page=40 is held through 3 cycles of req_ready=0.
  - A response for page 41 is ignored.
  - Response for page 40 with data 0x0100 -> val0 = 0x0199.
- tile_id=1, weight[1]=0x8000, FSM stalled in WAIT; query page 17 -> next cycle rpl_valid=1, rpl_data=435. Query page 3 -> rpl_data=0.
- With PAGERANK_TIMEOUT_EN, withhold the response -> req_valid reasserts 256 cycles after entering WAIT with the same req_page. Assert reset mid-run -> IDLE and reset values on the next cycle.
